// File: rtl/seq_mult_gen.sv
// Sequential shift-add multiplier: one partial product per clock, unsigned or
// two's-complement operands, start/busy/done handshake.
module seq_mult_gen #(
    parameter  int WIDTH = 8,
    localparam int CW    = $clog2(WIDTH) + 1
) (
    input  logic                 clk,
    input  logic                 rst,
    input  logic                 start,
    input  logic                 sgn,
    input  logic [WIDTH-1:0]     x,
    input  logic [WIDTH-1:0]     y,
    output logic                 busy,
    output logic                 done,
    output logic [2*WIDTH-1:0]   P,
    output logic [1:0]           dbg_state
);

    // Handshake: start is taken only in IDLE; busy is high in RUN and FIX;
    // done pulses for one cycle in the cycle P first shows the new result.
    typedef enum logic [1:0] {IDLE = 2'd0, RUN = 2'd1, FIX = 2'd2} state_t;

    localparam logic [2*WIDTH-1:0] ONE_P = {{(2*WIDTH-1){1'b0}}, 1'b1};
    localparam logic [WIDTH-1:0]   ONE_W = {{(WIDTH-1){1'b0}}, 1'b1};

    state_t               state_q, state_d;
    logic [CW-1:0]        cnt_q, cnt_d;
    logic [WIDTH-1:0]     mcand_q, mcand_d;
    logic [WIDTH-1:0]     acc_q, acc_d;
    logic [WIDTH-1:0]     mplier_q, mplier_d;
    logic                 neg_q, neg_d;
    logic [2*WIDTH-1:0]   p_q, p_d;
    logic                 done_q, done_d;

    logic [WIDTH:0]       sum;
    logic [WIDTH-1:0]     abs_x, abs_y;
    logic [2*WIDTH-1:0]   prod;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q  <= IDLE;
            cnt_q    <= '0;
            mcand_q  <= '0;
            acc_q    <= '0;
            mplier_q <= '0;
            neg_q    <= 1'b0;
            p_q      <= '0;
            done_q   <= 1'b0;
        end else begin
            state_q  <= state_d;
            cnt_q    <= cnt_d;
            mcand_q  <= mcand_d;
            acc_q    <= acc_d;
            mplier_q <= mplier_d;
            neg_q    <= neg_d;
            p_q      <= p_d;
            done_q   <= done_d;
        end
    end

    always_comb begin
        state_d  = state_q;
        cnt_d    = cnt_q;
        mcand_d  = mcand_q;
        acc_d    = acc_q;
        mplier_d = mplier_q;
        neg_d    = neg_q;
        p_d      = p_q;
        done_d   = 1'b0;

        // The most negative value maps to 2^(WIDTH-1) when read as unsigned.
        abs_x = (sgn && x[WIDTH-1]) ? (~x + ONE_W) : x;
        abs_y = (sgn && y[WIDTH-1]) ? (~y + ONE_W) : y;
        sum   = {1'b0, acc_q} + (mplier_q[0] ? {1'b0, mcand_q} : '0);
        prod  = {acc_q, mplier_q};

        case (state_q)
            IDLE: begin
                if (start) begin
                    mcand_d  = abs_x;
                    mplier_d = abs_y;
                    acc_d    = '0;
                    cnt_d    = '0;
                    neg_d    = sgn & (x[WIDTH-1] ^ y[WIDTH-1]);
                    state_d  = RUN;
                end
            end
            RUN: begin
                // Multiplier bits retire from the low end as product bits enter.
                acc_d    = sum[WIDTH:1];
                mplier_d = {sum[0], mplier_q[WIDTH-1:1]};
                cnt_d    = cnt_q + CW'(1);
                if (cnt_q == CW'(WIDTH - 1)) begin
                    state_d = FIX;
                end
            end
            FIX: begin
                p_d     = neg_q ? (~prod + ONE_P) : prod;
                done_d  = 1'b1;
                state_d = IDLE;
            end
            default: begin
                state_d = IDLE;
            end
        endcase
    end

    assign busy      = (state_q == RUN) || (state_q == FIX);
    assign done      = done_q;
    assign P         = p_q;
    assign dbg_state = state_q;

endmodule

// File: tb/tb_seq_mult_gen.sv
// Bench for seq_mult_gen: an 8-bit and a 4-bit instance checked every cycle
// against an arithmetic product model with a latency countdown.
module tb_seq_mult_gen;

    logic clk = 1'b0;
    logic rst;
    logic       start_a[2];
    logic       sgn_a[2];
    logic [7:0] x_a[2];
    logic [7:0] y_a[2];

    logic        busy8, done8, busy4, done4;
    logic [15:0] p8;
    logic [7:0]  p4;
    logic [1:0]  st8, st4;

    int n_cmp  = 0;
    int n_fail = 0;
    int done4_cnt = 0;

    always #5 clk = ~clk;

    seq_mult_gen #(.WIDTH(8)) dut8 (
        .clk(clk), .rst(rst), .start(start_a[0]), .sgn(sgn_a[0]),
        .x(x_a[0]), .y(y_a[0]), .busy(busy8), .done(done8), .P(p8),
        .dbg_state(st8)
    );

    seq_mult_gen #(.WIDTH(4)) dut4 (
        .clk(clk), .rst(rst), .start(start_a[1]), .sgn(sgn_a[1]),
        .x(x_a[1][3:0]), .y(y_a[1][3:0]), .busy(busy4), .done(done4), .P(p4),
        .dbg_state(st4)
    );

    function automatic logic [15:0] golden(int w, logic s, logic [7:0] a, logic [7:0] b);
        longint sa, sb, pr;
        sa = longint'(a);
        sb = longint'(b);
        if (s && a[w-1]) sa = sa - (longint'(1) << w);
        if (s && b[w-1]) sb = sb - (longint'(1) << w);
        pr = sa * sb;
        return 16'(pr & ((longint'(1) << (2 * w)) - 1));
    endfunction

    task automatic chk(input string nm, input logic [15:0] act, input logic [15:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %h want %h at %0t", nm, act, exp, $time);
        end
    endtask

    // Reference: an accepted request completes WIDTH+1 edges later.
    int          rem[2]      = '{0, 0};
    logic [15:0] pend[2]     = '{16'h0, 16'h0};
    logic [15:0] exp_p[2]    = '{16'h0, 16'h0};
    logic        exp_done[2] = '{1'b0, 1'b0};

    always @(posedge clk or posedge rst) begin
        for (int i = 0; i < 2; i++) begin
            if (rst) begin
                rem[i]      <= 0;
                pend[i]     <= '0;
                exp_p[i]    <= '0;
                exp_done[i] <= 1'b0;
            end else if (rem[i] == 0) begin
                exp_done[i] <= 1'b0;
                if (start_a[i]) begin
                    rem[i]  <= (i == 0 ? 8 : 4) + 1;
                    pend[i] <= golden(i == 0 ? 8 : 4, sgn_a[i], x_a[i], y_a[i]);
                end
            end else if (rem[i] == 1) begin
                rem[i]      <= 0;
                exp_p[i]    <= pend[i];
                exp_done[i] <= 1'b1;
            end else begin
                rem[i]      <= rem[i] - 1;
                exp_done[i] <= 1'b0;
            end
        end
    end

    always @(negedge clk) begin
        chk("busy8", {15'h0, busy8}, {15'h0, rem[0] != 0});
        chk("done8", {15'h0, done8}, {15'h0, exp_done[0]});
        chk("p8", p8, exp_p[0]);
        chk("busy4", {15'h0, busy4}, {15'h0, rem[1] != 0});
        chk("done4", {15'h0, done4}, {15'h0, exp_done[1]});
        chk("p4", {8'h0, p4}, exp_p[1]);
        if (done4) done4_cnt++;
    end

    function automatic logic get_done(int i);
        return (i == 0) ? done8 : done4;
    endfunction

    function automatic logic [15:0] get_p(int i);
        return (i == 0) ? p8 : {8'h0, p4};
    endfunction

    task automatic rnd_operands(input int i);
        x_a[i]   = (i == 0) ? 8'($urandom_range(0, 255)) : 8'($urandom_range(0, 15));
        y_a[i]   = (i == 0) ? 8'($urandom_range(0, 255)) : 8'($urandom_range(0, 15));
        sgn_a[i] = 1'($urandom_range(0, 1));
    endtask

    // Entered at a negedge; returns at the negedge where done is seen.
    task automatic wait_done(input int i, input string nm, input bit poke);
        bit got;
        got = 0;
        for (int c = 0; c < 30 && !got; c++) begin
            @(negedge clk);
            if (get_done(i)) begin
                got = 1;
                start_a[i] = 1'b0;
            end else if (poke) begin
                start_a[i] = 1'($urandom_range(0, 2) == 0);
                rnd_operands(i);
            end
        end
        if (!got) begin
            n_cmp++;
            n_fail++;
            $display("FAIL %s_timeout: got no done want done within 30 cycles", nm);
        end
    endtask

    task automatic run_op(input int i, input string nm, input logic s,
                          input logic [7:0] a, input logic [7:0] b,
                          input logic [15:0] lit);
        start_a[i] = 1'b1;
        sgn_a[i]   = s;
        x_a[i]     = a;
        y_a[i]     = b;
        @(negedge clk);
        start_a[i] = 1'b0;
        rnd_operands(i);
        wait_done(i, nm, 1'b0);
        chk({nm, "_dut"}, get_p(i), lit);
        chk({nm, "_model"}, exp_p[i], lit);
    endtask

    initial begin
        int nd;
        rst = 1'b1;
        for (int i = 0; i < 2; i++) begin
            start_a[i] = 1'b0;
            sgn_a[i]   = 1'b0;
            x_a[i]     = '0;
            y_a[i]     = '0;
        end
        repeat (3) @(negedge clk);
        chk("rst_p8", p8, 16'h0);
        chk("rst_busy8", {15'h0, busy8}, 16'h0);
        rst = 1'b0;
        @(negedge clk);

        run_op(0, "u13x11", 1'b0, 8'd13, 8'd11, 16'h008F);
        @(negedge clk);
        chk("done_low_after", {15'h0, done8}, 16'h0);
        run_op(0, "uFFxFF", 1'b0, 8'hFF, 8'hFF, 16'hFE01);
        run_op(0, "uFDx05", 1'b0, 8'hFD, 8'h05, 16'h04F1);
        run_op(0, "sFDx05", 1'b1, 8'hFD, 8'h05, 16'hFFF1);
        run_op(0, "s80x80", 1'b1, 8'h80, 8'h80, 16'h4000);
        run_op(0, "s80x7F", 1'b1, 8'h80, 8'h7F, 16'hC080);
        run_op(0, "s00x80", 1'b1, 8'h00, 8'h80, 16'h0000);

        // Start held high: each done cycle launches the next operation.
        @(negedge clk);
        start_a[0] = 1'b1;
        sgn_a[0]   = 1'b0;
        x_a[0]     = 8'd3;
        y_a[0]     = 8'd4;
        nd = 0;
        for (int c = 0; c < 30; c++) begin
            @(negedge clk);
            if (done8) nd++;
        end
        start_a[0] = 1'b0;
        chk("hold_done_count", 16'(nd), 16'd3);
        chk("hold_p", p8, 16'd12);

        // Asynchronous reset during the fourth busy cycle.
        @(negedge clk);
        start_a[0] = 1'b1;
        sgn_a[0]   = 1'b0;
        x_a[0]     = 8'd200;
        y_a[0]     = 8'd100;
        @(negedge clk);
        start_a[0] = 1'b0;
        repeat (3) @(negedge clk);
        #2 rst = 1'b1;
        #1;
        chk("arst_busy", {15'h0, busy8}, 16'h0);
        chk("arst_done", {15'h0, done8}, 16'h0);
        chk("arst_p", p8, 16'h0);
        @(negedge clk);
        rst = 1'b0;
        @(negedge clk);
        run_op(0, "after_rst", 1'b0, 8'd7, 8'd9, 16'd63);

        // Random traffic with ignored start pulses while busy.
        for (int n = 0; n < 40; n++) begin
            repeat ($urandom_range(0, 3)) @(negedge clk);
            start_a[0] = 1'b1;
            rnd_operands(0);
            @(negedge clk);
            start_a[0] = 1'b0;
            wait_done(0, "rand8", 1'b1);
        end

        // Exhaustive 4-bit sweep, back-to-back.
        @(negedge clk);
        chk("w4_model_pin", golden(4, 1'b1, 8'h8, 8'h8), 16'h0040);
        done4_cnt = 0;
        start_a[1] = 1'b1;
        for (int s = 0; s < 2; s++) begin
            for (int a = 0; a < 16; a++) begin
                for (int b = 0; b < 16; b++) begin
                    sgn_a[1] = 1'(s);
                    x_a[1]   = 8'(a);
                    y_a[1]   = 8'(b);
                    wait_done(1, "sweep4", 1'b0);
                    start_a[1] = 1'b1;
                end
            end
        end
        start_a[1] = 1'b0;
        repeat (10) @(negedge clk);
        chk("w4_done_count", 16'(done4_cnt), 16'd512);
        chk("w4_last_p", {8'h0, p4}, 16'h0001);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
        $finish;
    end

endmodule
